// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with power-of-two depth, programmable almost-full/empty
// thresholds, registered read data and sticky overflow/underflow flags.
module sync_fifo_param #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rd_en,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     rd_valid,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow,
    input  logic                     clr_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_LEVEL);
    localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_LEVEL);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              wr_acc;
    logic              rd_acc;

    // Status flags are decoded from the registered count only, so acceptance
    // below always sees the state from before the current edge.
    assign full         = (count == DEPTH_C);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AF_C);
    assign almost_empty = (count <= AE_C);

    assign wr_acc = wr_en & ~full;
    assign rd_acc = rd_en & ~empty;

    // Storage carries no reset; stale words are unreachable once the pointers
    // and count are cleared.
    always_ff @(posedge clk) begin
        if (wr_acc && !reset) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_acc;
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_acc) begin
                rd_data <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + PTR_W'(1);
            end
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // A new error in the same cycle as clr_err keeps its flag set.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en && full) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end
            if (rd_en && empty) begin
                underflow <= 1'b1;
            end else if (clr_err) begin
                underflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed self-checking bench for sync_fifo_param (DATA_W=8, DEPTH=16,
// AF_LEVEL=14, AE_LEVEL=2).
module tb_sync_fifo_param;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       rd_en = 1'b0;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [4:0] count;
    logic       overflow;
    logic       underflow;
    logic       clr_err = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    sync_fifo_param #(
        .DATA_W(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2)
    ) dut (
        .clk(clk), .reset(reset),
        .wr_en(wr_en), .wr_data(wr_data),
        .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
        .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty),
        .count(count), .overflow(overflow), .underflow(underflow),
        .clr_err(clr_err)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [19:0] got, exp;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        exp = {8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0};
        got = {rd_data, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow};
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected %h", got, exp);
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1;
            wr_data = 8'(i);
            tick();
            n_checks++;
            if (count !== 5'(i + 1)) begin
                n_fail++;
                $display("FAIL fill_count[%0d]: got %0d expected %0d", i, count, i + 1);
            end
            n_checks++;
            if ({almost_empty, almost_full, full} !==
                {(i + 1) <= 2, (i + 1) >= 14, (i + 1) == 16}) begin
                n_fail++;
                $display("FAIL fill_flags[%0d]: got ae/af/full=%b%b%b", i,
                         almost_empty, almost_full, full);
            end
        end
        wr_data = 8'h55;
        tick();
        wr_en = 1'b0;
        n_checks++;
        if (overflow !== 1'b1 || count !== 5'd16) begin
            n_fail++;
            $display("FAIL fill_overflow: got ovf=%b count=%0d expected ovf=1 count=16",
                     overflow, count);
        end
    endtask

    task automatic test_drain();
        for (int i = 0; i < 16; i++) begin
            rd_en = 1'b1;
            tick();
            n_checks++;
            if (rd_valid !== 1'b1 || rd_data !== 8'(i) || count !== 5'(15 - i)) begin
                n_fail++;
                $display("FAIL drain[%0d]: got vld=%b data=%h count=%0d expected 1 %h %0d",
                         i, rd_valid, rd_data, count, 8'(i), 15 - i);
            end
        end
        tick();
        rd_en = 1'b0;
        n_checks++;
        if (rd_valid !== 1'b0 || underflow !== 1'b1 || count !== 5'd0 ||
            empty !== 1'b1 || rd_data !== 8'h0F) begin
            n_fail++;
            $display("FAIL drain_underflow: got vld=%b unf=%b count=%0d empty=%b data=%h",
                     rd_valid, underflow, count, empty, rd_data);
        end
    endtask

    task automatic test_clr_err();
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        n_checks++;
        if (overflow !== 1'b0 || underflow !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_err: got ovf=%b unf=%b expected 0 0", overflow, underflow);
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 10; i++) begin
            wr_en = 1'b1; wr_data = 8'h10 + 8'(i); tick();
        end
        wr_en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            rd_en = 1'b1; tick();
            n_checks++;
            if (rd_valid !== 1'b1 || rd_data !== 8'h10 + 8'(i)) begin
                n_fail++;
                $display("FAIL wrap_a[%0d]: got vld=%b data=%h expected %h",
                         i, rd_valid, rd_data, 8'h10 + 8'(i));
            end
        end
        rd_en = 1'b0;
        for (int i = 0; i < 12; i++) begin
            wr_en = 1'b1; wr_data = 8'hA0 + 8'(i); tick();
        end
        wr_en = 1'b0;
        n_checks++;
        if (count !== 5'd12) begin
            n_fail++;
            $display("FAIL wrap_count: got %0d expected 12", count);
        end
        for (int i = 0; i < 12; i++) begin
            rd_en = 1'b1; tick();
            n_checks++;
            if (rd_valid !== 1'b1 || rd_data !== 8'hA0 + 8'(i)) begin
                n_fail++;
                $display("FAIL wrap_b[%0d]: got vld=%b data=%h expected %h",
                         i, rd_valid, rd_data, 8'hA0 + 8'(i));
            end
        end
        rd_en = 1'b0;
        tick();
        n_checks++;
        if (empty !== 1'b1 || rd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_empty: got empty=%b vld=%b", empty, rd_valid);
        end
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 5; i++) begin
            wr_en = 1'b1; wr_data = 8'h30 + 8'(i); tick();
        end
        for (int i = 0; i < 20; i++) begin
            wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'h35 + 8'(i); tick();
            n_checks++;
            if (count !== 5'd5 || rd_valid !== 1'b1 || rd_data !== 8'h30 + 8'(i)) begin
                n_fail++;
                $display("FAIL simul[%0d]: got count=%0d vld=%b data=%h expected 5 1 %h",
                         i, count, rd_valid, rd_data, 8'h30 + 8'(i));
            end
        end
        rd_en = 1'b0;
        for (int i = 0; i < 11; i++) begin
            wr_en = 1'b1; wr_data = 8'h49 + 8'(i); tick();
        end
        n_checks++;
        if (full !== 1'b1 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL simul_full: got full=%b ovf=%b expected 1 0", full, overflow);
        end
        wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'hEE; tick();
        wr_en = 1'b0; rd_en = 1'b0;
        n_checks++;
        if (count !== 5'd15 || overflow !== 1'b1 || rd_valid !== 1'b1 || rd_data !== 8'h44) begin
            n_fail++;
            $display("FAIL simul_at_full: got count=%0d ovf=%b vld=%b data=%h expected 15 1 1 44",
                     count, overflow, rd_valid, rd_data);
        end
    endtask

    task automatic test_errors();
        wr_en = 1'b1; wr_data = 8'h54; tick();
        wr_en = 1'b0;
        clr_err = 1'b1; tick();
        clr_err = 1'b0;
        n_checks++;
        if (overflow !== 1'b0 || full !== 1'b1) begin
            n_fail++;
            $display("FAIL err_clear: got ovf=%b full=%b expected 0 1", overflow, full);
        end
        clr_err = 1'b1; wr_en = 1'b1; wr_data = 8'h77; tick();
        clr_err = 1'b0; wr_en = 1'b0;
        n_checks++;
        if (overflow !== 1'b1 || count !== 5'd16) begin
            n_fail++;
            $display("FAIL err_set_wins: got ovf=%b count=%0d expected 1 16", overflow, count);
        end
        for (int i = 0; i < 16; i++) begin
            rd_en = 1'b1; tick();
            n_checks++;
            if (rd_valid !== 1'b1 || rd_data !== 8'h45 + 8'(i)) begin
                n_fail++;
                $display("FAIL err_drain[%0d]: got vld=%b data=%h expected %h",
                         i, rd_valid, rd_data, 8'h45 + 8'(i));
            end
        end
        rd_en = 1'b1; wr_en = 1'b1; wr_data = 8'h99; tick();
        rd_en = 1'b0; wr_en = 1'b0;
        n_checks++;
        if (count !== 5'd1 || rd_valid !== 1'b0 || underflow !== 1'b1) begin
            n_fail++;
            $display("FAIL simul_at_empty: got count=%0d vld=%b unf=%b expected 1 0 1",
                     count, rd_valid, underflow);
        end
    endtask

    task automatic test_reset_mid_op();
        logic [18:0] got, exp;
        for (int i = 0; i < 6; i++) begin
            wr_en = 1'b1; wr_data = 8'h60 + 8'(i); tick();
        end
        wr_en = 1'b0;
        n_checks++;
        if (count !== 5'd7) begin
            n_fail++;
            $display("FAIL midrst_pre_count: got %0d expected 7", count);
        end
        reset = 1'b1; wr_en = 1'b1; rd_en = 1'b1; clr_err = 1'b0; wr_data = 8'hBB; tick();
        reset = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        exp = {8'h00, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0};
        got = {rd_data, rd_valid, empty, count, overflow, underflow, almost_empty, full};
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL midrst_state: got %h expected %h", got, exp);
        end
        wr_en = 1'b1; wr_data = 8'hC3; tick();
        wr_en = 1'b0; rd_en = 1'b1; tick();
        rd_en = 1'b0;
        n_checks++;
        if (rd_valid !== 1'b1 || rd_data !== 8'hC3 || count !== 5'd0) begin
            n_fail++;
            $display("FAIL midrst_new_data: got vld=%b data=%h count=%0d expected 1 c3 0",
                     rd_valid, rd_data, count);
        end
        rd_en = 1'b1; tick();
        rd_en = 1'b0;
        n_checks++;
        if (rd_valid !== 1'b0 || rd_data !== 8'hC3 || underflow !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_no_stale: got vld=%b data=%h unf=%b expected 0 c3 1",
                     rd_valid, rd_data, underflow);
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_fill();
        test_drain();
        test_clr_err();
        test_wrap();
        test_simultaneous();
        test_errors();
        test_reset_mid_op();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Parametrised single-clock FIFO for buffering data between producer and consumer stages in the verification and datapath blocks. It supports configurable data width, power-of-two depth and programmable almost-full/almost-empty thresholds. Simultaneous read and write in the same cycle are both accepted. Overflow and underflow attempts raise sticky error flags, and a full-range occupancy count is exported.

## Interface
- DATA_W, 8: data word width in bits (≥1)
- DEPTH, 16: number of entries; power of two, ≥4
- AF_LEVEL, DEPTH-2: almost_full asserts when count ≥ AF_LEVEL (1..DEPTH)
- AE_LEVEL, 2: almost_empty asserts when count ≤ AE_LEVEL (0..DEPTH-1)

Ports:
- clk  in  1  clock; all logic on rising edge
- reset  in  1  reset, synchronous, active-high
- wr_en  in  1  write request
- wr_data  in  DATA_W  write data
- rd_en  in  1  read request
- rd_data  out  DATA_W  registered read data
- rd_valid  out  1  one-cycle pulse; rd_data holds a word popped on the previous edge
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count ≥ AF_LEVEL
- almost_empty  out  1  count ≤ AE_LEVEL
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- overflow  out  1  sticky; set by a rejected write
- underflow  out  1  sticky; set by a rejected read
- clr_err  in  1  clears overflow and underflow

## Operation
- Storage: DEPTH×DATA_W array, not reset. Pointers: wr_ptr and rd_ptr, $clog2(DEPTH) bits each, wrapping naturally from DEPTH-1 to 0.
- Write acceptance: wr_acc = wr_en & ~full. On an accepted write, mem[wr_ptr] ← wr_data and wr_ptr increments.
- Read acceptance: rd_acc = rd_en & ~empty. On an accepted read, rd_data ← mem[rd_ptr], rd_ptr increments, and rd_valid = 1 in the next cycle.
- Acceptance uses the flags registered before the edge. There is no bypass.
- Simultaneous requests:
  - Neither full nor empty: both are accepted and count is unchanged.
  - Full: the read is accepted and the write is rejected; overflow is set.
  - Empty: the write is accepted and the read is rejected; underflow is set.
- count update: +1 on write-only, −1 on read-only, unchanged on both or neither. count never leaves 0..DEPTH.
- Error flags:
  - overflow ← 1 on wr_en & full.
  - underflow ← 1 on rd_en & empty.
  - A rejected access changes no pointer, count or data.
  - clr_err clears both flags. If a new error occurs in the same cycle as clr_err, the flag stays set (set wins).
- Flags are pure decodes of registered count.
- rd_data holds its last value when no read is accepted.
- reset:
  - Clears pointers, count, rd_data (to 0), rd_valid, overflow and underflow.
  - Overrides wr_en, rd_en and clr_err in the same cycle.
  - Reset mid-operation discards all contents: after reset, empty = 1 and stale data is never returned.

## Timing
- Reset values: rd_data=0, rd_valid=0, full=0, empty=1, almost_full=0, almost_empty=1, count=0, overflow=0, underflow=0.
- Write-to-flag latency: count and flags reflect an accepted write one cycle after the edge at which wr_en was sampled.
- Write-to-read latency: a word written at edge N can be accepted for read at edge N+1 at the earliest. It appears on rd_data after edge N+1.
- Read latency: rd_en sampled at edge N gives rd_data and rd_valid valid from edge N until edge N+1.
- Throughput: one write and one read per cycle, sustained indefinitely at any occupancy except the full/empty boundaries.
- Error flags set one cycle after the offending request is sampled.

## Test plan
All scenarios use DATA_W=8, DEPTH=16, AF_LEVEL=14, AE_LEVEL=2.

- Reset check: assert reset 2 cycles -> all outputs at their reset values; count=0, empty=1.
- Fill: write 0x00..0x0F on consecutive cycles.
  - almost_empty drops after the 3rd write.
  - almost_full rises after the 14th write.
  - full=1 and count=16 after the 16th write.
  - A 17th write sets overflow=1 and leaves count=16.
- Drain: read 16 times -> rd_data returns 0x00..0x0F in order, each with rd_valid; empty=1 afterwards. An extra read sets underflow=1, keeps count=0 and gives no rd_valid.
- Wrap-around: write 10 words, read 10 words, write 12 more (0xA0..0xAB), read 12 -> data 0xA0..0xAB in order; pointers wrap past 15 cleanly.
- Simultaneous:
  - At count=5, wr_en=rd_en=1 for 20 cycles -> count stays 5 and data stays in order.
  - At full, wr_en=rd_en=1 -> read accepted, count=15, overflow=1.
  - At empty, wr_en=rd_en=1 -> write accepted, count=1, no rd_valid, underflow=1.
- Errors and reset mid-operation:
  - clr_err with no new error -> overflow and underflow clear next cycle.
  - clr_err alongside a rejected write -> overflow remains 1.
  - Reset at count=7 -> count=0, empty=1; the next write/read returns the new data only.
